// File: rtl/uart_rx_fsm.sv
// UART receiver: start detect, mid-bit sampling, optional parity, 1-2 stop bits, one-word output buffer.
// Latency: rx_valid (or an error pulse) appears 1 clk after the final stop-bit rx_baud_tick.
// Backpressure: the single-word buffer holds until rx_valid && rx_ready; a frame completing while full is dropped with overrun_err.
//
// Ports:
//   clk, rst_n            clock; reset is asynchronous and active-high (rst_n = 1 resets)
//   rx_serial             asynchronous serial line, idles high
//   rx_half_baud_tick     mid-start-bit pulse from the baud generator
//   rx_baud_tick          per-bit pulse from the baud generator while rx_en = 1
//   rx_start_align        asks the generator to start half-baud alignment
//   rx_en                 enables the generator's full-baud ticking
//   rx_data/rx_valid/rx_ready   received word with valid/ready handshake
//   parity_err, framing_err, overrun_err   1-clk pulses, the frame is dropped
module uart_rx_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_serial,
    input  logic                 rx_half_baud_tick,
    input  logic                 rx_baud_tick,
    output logic                 rx_start_align,
    output logic                 rx_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);

    logic                 sync_q1;
    logic                 s_rx;
    logic                 s_rx_prev;
    logic [2:0]           state;
    logic [2:0]           cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 frame_bad;
    logic                 exp_par;
    logic                 frame_done;
    logic                 stop_bad_now;

    assign exp_par      = (^shreg) ^ PAR_ODD;
    // The final stop tick is the completion point; its own sample is folded in
    // combinationally so the verdict lands exactly one clock later.
    assign frame_done   = (state == STOP) && rx_baud_tick && (cnt == LAST_STOP);
    assign stop_bad_now = frame_bad | ~s_rx;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    // Resetting to 1 (idle line) avoids a false start edge after reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q1   <= 1'b1;
            s_rx      <= 1'b1;
            s_rx_prev <= 1'b1;
        end else begin
            sync_q1   <= rx_serial;
            s_rx      <= sync_q1;
            s_rx_prev <= s_rx;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            shreg          <= '0;
            par_bad        <= 1'b0;
            frame_bad      <= 1'b0;
            rx_start_align <= 1'b0;
            rx_en          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Only a 1->0 edge arms; a line held low (break) never re-arms.
                    if (s_rx_prev && !s_rx) begin
                        state          <= START;
                        rx_start_align <= 1'b1;
                    end
                end
                START: begin
                    if (rx_half_baud_tick) begin
                        rx_start_align <= 1'b0;
                        if (!s_rx) begin
                            rx_en     <= 1'b1;
                            cnt       <= '0;
                            par_bad   <= 1'b0;
                            frame_bad <= 1'b0;
                            state     <= DATA;
                        end else begin
                            state <= IDLE;      // start bit was a glitch
                        end
                    end
                end
                DATA: begin
                    if (rx_baud_tick) begin
                        // Right shift: after DATA_BITS samples the first (LSB) bit sits in bit 0.
                        shreg <= {s_rx, shreg[DATA_BITS-1:1]};
                        if (cnt == LAST_DATA) begin
                            cnt   <= '0;
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (rx_baud_tick) begin
                        par_bad <= (s_rx != exp_par);
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (rx_baud_tick) begin
                        frame_bad <= stop_bad_now;
                        if (cnt == LAST_STOP) begin
                            rx_en <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    rx_start_align <= 1'b0;
                    rx_en          <= 1'b0;
                end
            endcase
        end
    end

    // Output buffer and error pulses.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (frame_done) begin
                if (stop_bad_now) begin
                    framing_err <= 1'b1;
                end else if (par_bad) begin
                    parity_err <= 1'b1;
                end else if (rx_valid && !rx_ready) begin
                    overrun_err <= 1'b1;        // old word is kept
                end else begin
                    // Also covers accept-and-load in the same cycle: valid stays high.
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- UART receiver that consumes the rx tick outputs of the baud generator: `rx_baud_tick` and `rx_half_baud_tick`.
- Drives the generator's `rx_start_align` and `rx_en` controls.
- Detects the start bit, samples each bit at mid-bit, checks optional parity and the stop bit(s).
- Presents each received byte on a valid/ready output buffer to the downstream consumer.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal 5..8; sent LSB first.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits checked; legal 1 or 2.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- rst_n  input  1  reset, asynchronous, active-high.
- rx_serial  input  1  asynchronous serial line; idles high.
- rx_half_baud_tick  input  1  1-clk pulse from the generator at mid start bit after `rx_start_align`.
- rx_baud_tick  input  1  1-clk pulse from the generator, once per bit period while `rx_en`=1.
- rx_start_align  output  1  requests half-baud alignment in the generator.
- rx_en  output  1  enables full-baud ticking in the generator.
- rx_data  output  DATA_BITS  received data word.
- rx_valid  output  1  `rx_data` holds an unconsumed word.
- rx_ready  input  1  consumer accepts the word.
- parity_err  output  1  1-clk pulse: parity mismatch; frame dropped.
- framing_err  output  1  1-clk pulse: stop bit sampled 0; frame dropped.
- overrun_err  output  1  1-clk pulse: frame completed while the buffer was full; new frame dropped.

Behaviour:
- Reset (`rst_n`=1, async): state=IDLE.
  - Synchroniser flops = 1.
  - All outputs 0, including `rx_data`.
- Input: `rx_serial` passes through a 2-FF synchroniser; s_rx denotes its output. Start detect uses the registered previous s_rx (falling edge 1->0).
- Generator contract:
  - First `rx_half_baud_tick` arrives half a bit after `rx_start_align` rises.
  - First `rx_baud_tick` arrives one full bit after `rx_en` rises.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on s_rx falling edge -> START; `rx_start_align`=1 from the next cycle.
  - START: wait for `rx_half_baud_tick`.
    - If s_rx=0 at the tick: `rx_start_align`->0, `rx_en`->1, bit counter=0 -> DATA.
    - If s_rx=1 at the tick (glitch): `rx_start_align`->0 -> IDLE. No error flag.
  - DATA: on each `rx_baud_tick`, shift s_rx into `shreg[cnt]` (LSB first). After bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: on `rx_baud_tick`, compare s_rx with the computed parity (XOR of data, inverted if PARITY_ODD). Result is held until STOP. -> STOP.
  - STOP: on each `rx_baud_tick`, sample s_rx. After the last stop bit: `rx_en`->0 -> IDLE.
    - Any stop sample of 0 flags framing.
- Frame completion, the cycle after the final stop tick, evaluated in priority order:
  1. framing_err: pulse `framing_err`.
  2. Else parity mismatch: pulse `parity_err`.
  3. Else buffer full and not being drained: pulse `overrun_err`; old data retained.
  4. Else load `rx_data`=shreg and set `rx_valid`=1.
- Handshake:
  - `rx_valid` is held with `rx_data` stable until a cycle with `rx_valid`&&`rx_ready`; `rx_valid` clears on the next edge.
  - Accept and completion in the same cycle: the new word loads, `rx_valid` stays 1, no overrun.
- Tick qualification: ticks received outside the expected state are ignored. `rx_half_baud_tick` and `rx_baud_tick` both high in one cycle: only the tick relevant to the current state acts.
- Break handling: after framing_err, IDLE re-arms only on a new 1->0 edge, so a held-low break produces exactly one `framing_err`.
- Reset mid-frame: immediate return to reset state; the partial frame is discarded; no error pulses.
- Latency: `rx_valid` rises 1 clk after the final stop-bit `rx_baud_tick`.

Test Plan:
- Frame 0xA5, 8N1, 115200 baud (8680 ns/bit) with the baud_gen instance -> `rx_data`=0xA5, `rx_valid`=1 about 1 clk after the stop tick; `rx_ready` pulse clears `rx_valid` next cycle.
- 2000 ns low glitch on the idle line -> START aborts at the half tick; `rx_en` never asserted; no `rx_valid`, no error pulse.
- Frame 0x3C with stop bit driven 0, then line held low for 50 us -> exactly one `framing_err` pulse; `rx_valid` stays 0; next good frame 0x11 received.
- PARITY_EN=1, even parity, frame 0x07 with parity bit 0 (wrong) -> `parity_err` pulse, no `rx_valid`. Same frame with parity bit 1 -> `rx_data`=0x07.
- Two back-to-back frames 0x55 then 0xAA with `rx_ready`=0 -> `rx_data` stays 0x55, `overrun_err` pulse at the second stop. Repeat with `rx_ready`=1 in the completion cycle -> `rx_data`=0xAA, no overrun.
- Assert `rst_n` during data bit 4 of a frame -> all outputs 0 immediately; next full frame 0xC3 received correctly.
